// File: rtl/reg_pkg.sv
// Shared register-file definitions: architectural register numbers,
// default widths and the basic word/address types. The ALU control and
// decode blocks import this same package.
package reg_pkg;

  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_SP   = 5'd29;
  localparam reg_addr_t REG_RA   = 5'd31;

  localparam word_t SP_INIT_DEFAULT = 32'h0000_0FFC;

endpackage

// File: rtl/reg_file.sv
// MIPS general-purpose register file: two combinational read ports feeding
// the ALU, one synchronous write port for writeback, and a debug read port.
// $0 always reads zero and is never stored; $sp comes out of reset preset.
module reg_file
  import reg_pkg::*;
#(
  parameter int unsigned       DATA_W  = REG_DATA_W,
  parameter int unsigned       ADDR_W  = REG_ADDR_W,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEFAULT),
  parameter bit                BYPASS  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] SP_ADDR   = ADDR_W'(REG_SP);

  typedef logic [DATA_W-1:0] word_array_t [DEPTH];

  word_array_t regs_q;
  word_array_t regs_d;

  logic write_hit;

  // Per-entry reset value: the stack pointer starts at SP_INIT, everything
  // else starts at zero so no output can ever show X.
  function automatic logic [DATA_W-1:0] reset_value(input int unsigned idx);
    logic [DATA_W-1:0] value;
    value = '0;
    if (ADDR_W'(idx) == SP_ADDR) begin
      value = SP_INIT;
    end
    return value;
  endfunction

  // Shared read mux for rd1, rd2 and dbg_data. Address 0 short-circuits to
  // zero regardless of what the array holds. With byp_en set, a write in
  // flight to the same (nonzero) address is forwarded; the address check
  // against zero already guarantees the write is not a discarded $0 write.
  function automatic logic [DATA_W-1:0] read_mux(
    input word_array_t       regs,
    input logic [ADDR_W-1:0] addr,
    input logic              byp_en,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    logic [DATA_W-1:0] data;
    data = '0;
    if (addr != ZERO_ADDR) begin
      data = regs[addr];
      if (byp_en && wr_en && (wr_addr == addr)) begin
        data = wr_data;
      end
    end
    return data;
  endfunction

  // A write only counts when enabled and not aimed at $0.
  assign write_hit = we && (wa != ZERO_ADDR);

  // Next-state of the array: hold everything, overwrite the addressed entry
  // on a valid write, and pin entry 0 to zero so it never holds a value.
  always_comb begin
    regs_d = regs_q;
    if (write_hit) begin
      regs_d[wa] = wd;
    end
    regs_d[0] = '0;
  end

  // Storage update; reset is asynchronous and overrides any write on the
  // same edge, so a write coinciding with reset is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= reset_value(i);
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // ALU operand ports may forward the in-flight write when BYPASS is set;
  // the debug port always shows the stored value.
  assign rd1      = read_mux(regs_q, ra1, BYPASS, we, wa, wd);
  assign rd2      = read_mux(regs_q, ra2, BYPASS, we, wa, wd);
  assign dbg_data = read_mux(regs_q, dbg_addr, 1'b0, we, wa, wd);

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file. Two instances share every input: one without
// write forwarding and one with it, so read-during-write behaviour of both
// variants is compared against the same reference register array.
`timescale 1ns/1ps
module tb_reg_file;

  localparam int          DATA_W  = 32;
  localparam int          ADDR_W  = 5;
  localparam logic [31:0] SP_INIT = 32'h0000_0FFC;
  localparam int          SP_REG  = 29;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa, dbg_addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd1_n, rd2_n, dbg_n;
  logic [31:0] rd1_b, rd2_b, dbg_b;

  int checks;
  int errors;

  // Reference register contents, indexed by register number.
  logic [31:0] model [32];

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SP_INIT(SP_INIT), .BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .we(we), .wa(wa), .wd(wd), .dbg_addr(dbg_addr), .dbg_data(dbg_n)
  );

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SP_INIT(SP_INIT), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .we(we), .wa(wa), .wd(wd), .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelReset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[SP_REG] = SP_INIT;
  endtask

  // Expected read value: $0 is zero, otherwise the stored value, replaced
  // by the write data when forwarding is enabled and the write targets it.
  function automatic logic [31:0] expRead(input logic [4:0] addr, input bit byp);
    if (addr == 5'd0) return 32'h0;
    if (byp && rst_n && we && (wa == addr)) return wd;
    return model[addr];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive all inputs just after a falling edge, away from the active edge.
  task automatic applyStimulus(input logic we_i, input logic [4:0] wa_i,
                               input logic [31:0] wd_i, input logic [4:0] ra1_i,
                               input logic [4:0] ra2_i, input logic [4:0] dbg_i);
    @(negedge clk);
    we = we_i; wa = wa_i; wd = wd_i;
    ra1 = ra1_i; ra2 = ra2_i; dbg_addr = dbg_i;
    #1;
  endtask

  // Cross one rising edge and apply the write to the model as it lands.
  task automatic stepEdge();
    @(posedge clk);
    if (rst_n && we && (wa != 5'd0)) model[wa] = wd;
    #1;
  endtask

  // Compare every output of both instances against the model.
  task automatic checkAll(input string tag);
    checkOutput({tag, ":rd1_nobyp"}, rd1_n, expRead(ra1, 1'b0));
    checkOutput({tag, ":rd2_nobyp"}, rd2_n, expRead(ra2, 1'b0));
    checkOutput({tag, ":rd1_byp"},   rd1_b, expRead(ra1, 1'b1));
    checkOutput({tag, ":rd2_byp"},   rd2_b, expRead(ra2, 1'b1));
    checkOutput({tag, ":dbg_nobyp"}, dbg_n, expRead(dbg_addr, 1'b0));
    checkOutput({tag, ":dbg_byp"},   dbg_b, expRead(dbg_addr, 1'b0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dbg_addr = '0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Put a value in r3 so the asynchronous reset has something to clear.
    applyStimulus(1'b1, 5'd3, 32'hCAFE_0003, 5'd3, 5'd3, 5'd3);
    stepEdge();
    checkOutput("pre_reset_r3", dbg_n, 32'hCAFE_0003);

    // Reset pulsed mid-cycle: the clear must show before any clock edge.
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd29, 5'd3);
    #1 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset_r3_dbg", dbg_n, 32'h0);
    checkOutput("async_reset_r3_rd1", rd1_n, 32'h0);
    checkOutput("async_reset_sp_rd2", rd2_n, SP_INIT);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #1;
      checkOutput($sformatf("reset_sweep_r%0d", a), dbg_n,
                  (a == SP_REG) ? SP_INIT : 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Write/read of r5: old value before the edge, new value after.
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
    checkOutput("wr5_rd1_before", rd1_n, 32'h0);
    checkOutput("wr5_rd1_byp_before", rd1_b, 32'hDEAD_BEEF);
    checkAll("wr5_before");
    stepEdge();
    checkOutput("wr5_rd1_after", rd1_n, 32'hDEAD_BEEF);
    checkOutput("wr5_rd2_after", rd2_n, 32'hDEAD_BEEF);

    // Writes to $0 are discarded.
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    checkOutput("r0_byp_before", rd1_b, 32'h0);
    stepEdge();
    checkOutput("r0_rd1_after", rd1_n, 32'h0);
    checkOutput("r0_dbg_after", dbg_n, 32'h0);

    // Read-during-write on r7 with and without forwarding.
    applyStimulus(1'b1, 5'd7, 32'h1, 5'd7, 5'd7, 5'd7);
    stepEdge();
    applyStimulus(1'b1, 5'd7, 32'h2, 5'd7, 5'd7, 5'd7);
    checkOutput("rdw7_nobyp_before", rd1_n, 32'h1);
    checkOutput("rdw7_byp_before", rd1_b, 32'h2);
    checkOutput("rdw7_byp_dbg_before", dbg_b, 32'h1);
    stepEdge();
    checkOutput("rdw7_nobyp_after", rd1_n, 32'h2);
    checkOutput("rdw7_byp_dbg_after", dbg_b, 32'h2);

    // Reset arriving with a write pending: the write must be lost.
    applyStimulus(1'b1, 5'd29, 32'h1234, 5'd29, 5'd8, 5'd29);
    stepEdge();
    applyStimulus(1'b1, 5'd8, 32'h1234, 5'd29, 5'd8, 5'd8);
    stepEdge();
    checkOutput("mid_r29_written", rd1_n, 32'h1234);
    checkOutput("mid_r8_written", rd2_n, 32'h1234);
    applyStimulus(1'b1, 5'd8, 32'h5, 5'd29, 5'd8, 5'd8);
    #2 rst_n = 1'b0;
    modelReset();
    stepEdge();
    checkOutput("mid_reset_r8", dbg_n, 32'h0);
    checkOutput("mid_reset_r29", rd1_n, SP_INIT);
    checkOutput("mid_reset_r8_rd2", rd2_n, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b0;

    // Random sweep against the reference array.
    for (int cyc = 0; cyc < 1000; cyc++) begin
      applyStimulus(1'($urandom_range(1, 0)), 5'($urandom), $urandom,
                    5'($urandom), 5'($urandom),
                    (cyc % 50 == 0) ? 5'd0 : 5'($urandom));
      checkAll($sformatf("rand%0d", cyc));
      stepEdge();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    checkOutput("final_r0_rd1", rd1_n, 32'h0);
    checkOutput("final_r0_dbg", dbg_n, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
